// File: rtl/count_sampler_if.sv
// count_sampler_if - stream/control bundle for count_sampler.
//   slave  : sampler side (consumes q/trig/out_ready/clr_ovf, drives results)
//   master : environment side (counter source + stream consumer)
//   q         8b   counter value from upstream
//   trig      1b   capture strobe
//   out_valid 1b   head entry available
//   out_ready 1b   consumer accepts head
//   out_data  8b   captured counter value at head
//   out_tag   4b   wrap count at capture time
//   level     $clog2(DEPTH)+1 bits, FIFO occupancy
//   overflow  1b   sticky drop flag
//   clr_ovf   1b   clears overflow
interface count_sampler_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    q;
    logic          trig;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [3:0]    out_tag;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_ovf;

    modport slave (
        input  q, trig, out_ready, clr_ovf,
        output out_valid, out_data, out_tag, level, overflow
    );

    modport master (
        output q, trig, out_ready, clr_ovf,
        input  out_valid, out_data, out_tag, level, overflow
    );
endinterface

// File: rtl/count_sampler.sv
// count_sampler - captures the upstream counter value on trig into a small
// FIFO and streams samples out over valid/ready.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : count_sampler_if.slave (q, trig, out_* stream, level, overflow, clr_ovf)
// Build option: COUNT_SAMPLER_WRAP_TAG_EN adds a wrap detector and stores a
// 4-bit wrap tag per entry; without it out_tag is tied to zero.
module count_sampler #(
    parameter int DEPTH     = 4,
    parameter int MAX_COUNT = 128
) (
    input  logic             clk,
    input  logic             rst,
    count_sampler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef COUNT_SAMPLER_WRAP_TAG_EN
    localparam int EW = 12;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_r;
    logic          ovf_r;
    logic [EW-1:0] entry;

    logic full, pop, push, ovf_set;

    assign full    = (level_r == LW'(DEPTH));
    assign pop     = (level_r != '0) && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = bus.trig && (!full || pop);
    assign ovf_set = bus.trig && full && !pop;

`ifdef COUNT_SAMPLER_WRAP_TAG_EN
    logic [7:0] prev_q;
    logic [3:0] wrap_cnt;
    logic       wrap_evt;

    // Only a MAX_COUNT -> 0 step counts; an upstream reset from any other
    // value lands on 0 without a wrap.
    assign wrap_evt = (prev_q == 8'(MAX_COUNT)) && (bus.q == 8'd0);
    // A wrap in the capture cycle is already reflected in the tag.
    assign entry    = {wrap_cnt + {3'b000, wrap_evt}, bus.q};

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= 8'd0;
            wrap_cnt <= 4'd0;
        end else begin
            prev_q <= bus.q;
            if (wrap_evt) wrap_cnt <= wrap_cnt + 4'd1;
        end
    end

    assign bus.out_tag = mem[rd_ptr][11:8];
`else
    assign entry       = bus.q;
    assign bus.out_tag = 4'd0;
`endif

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level_r <= level_r + LW'(1);
            else if (pop && !push) level_r <= level_r - LW'(1);
            // Set has priority over clear.
            if (ovf_set)          ovf_r <= 1'b1;
            else if (bus.clr_ovf) ovf_r <= 1'b0;
        end
    end

    assign bus.out_valid = (level_r != '0);
    assign bus.out_data  = mem[rd_ptr][7:0];
    assign bus.level     = level_r;
    assign bus.overflow  = ovf_r;
endmodule
